epp_regfile: RTL and testbench
==============================

EPP_REGFILE -- requirements
Module: epp_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 8-bit host-accessible registers, range 1..255.
REQ-002 SHALL have parameter AUTO_INC, default 1: 1 means the address register post-increments after every data cycle.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for Astb/Dstb/Wr, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Db, inout, 8 bits: EPP data bus.
REQ-007 SHALL have ports Astb and Dstb, each input, 1 bit: address strobe and data strobe, both active low.
REQ-008 SHALL have port Wr, input, 1 bit: 0 = host write, 1 = host read.
REQ-009 SHALL have port Wait, output, 1 bit: strobe acknowledge.
REQ-010 SHALL have port regs_out, output, 8*NUM_REGS bits: flattened register file; register i occupies bits [8i+7:8i].
REQ-011 SHALL have port status_in, input, 8 bits: read-only status, returned at address 0xFF.
REQ-012 SHALL have ports wr_stb (output, 1 bit), wr_addr (output, 8 bits) and wr_data (output, 8 bits): one-cycle pulse per committed host data write.
REQ-013 SHALL have port addr_out, output, 8 bits: current EPP address register.

Function
REQ-014 SHALL pass Astb, Dstb and Wr through SYNC_STAGES flops before use; Db is sampled unsynchronised.
REQ-015 SHALL implement states IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, RELEASE.
REQ-016 IDLE SHALL dispatch on synced strobes: Astb low with Wr=0 goes to ADDR_WR; Astb low with Wr=1 goes to ADDR_RD; otherwise Dstb low with Wr=0 goes to DATA_WR; Dstb low with Wr=1 goes to DATA_RD. Astb takes priority when both strobes are low.
REQ-017 ADDR_WR SHALL load the address register from Db. DATA_WR SHALL write Db to register[addr] and pulse wr_stb for one cycle with wr_addr/wr_data. Both then go to RELEASE with Wait=1.
REQ-018 ADDR_RD SHALL load the output latch with the address register. DATA_RD SHALL load the output latch with: register[addr] if addr<NUM_REGS; status_in if addr==0xFF; 0x00 otherwise. Both assert the bus drive enable, then go to RELEASE, with Wait rising one cycle after the latch is loaded.
REQ-019 A write to addr>=NUM_REGS (including 0xFF) SHALL be ignored (no register change) but SHALL still pulse wr_stb and complete the handshake.
REQ-020 RELEASE SHALL hold Wait=1 until the active synced strobe is high, then drive Wait=0, release the bus, and return to IDLE in the same cycle.
REQ-021 With AUTO_INC=1, each completed data cycle SHALL increment addr modulo 256 (0xFF wraps to 0x00) on RELEASE exit; address cycles SHALL never increment.
REQ-022 Db SHALL be driven only while the drive enable is set (read cycles, from latch load to RELEASE exit); otherwise Db is high-Z. Wr alone SHALL never enable the driver.
REQ-023 Latency: Wait SHALL rise within SYNC_STAGES+2 clk cycles of the strobe falling at the pin, and fall within SYNC_STAGES+1 cycles of the strobe rising.
REQ-024 A strobe that is already low on return to IDLE SHALL start a new cycle; the same strobe assertion SHALL never be serviced twice.

Reset
REQ-025 On rst: state=IDLE, Wait=0, drive enable=0 (Db high-Z), output latch=0x00, addr=0x00, every register=0x00, wr_stb=0, wr_addr=0x00, wr_data=0x00.
REQ-026 rst mid-cycle SHALL abort immediately; an in-progress write SHALL NOT commit; after rst releases, a still-low strobe is serviced as a new cycle.

Structure
REQ-027 Package epp_pkg SHALL hold the state enumeration, STATUS_ADDR=8'hFF and the bus width constant EPP_W=8.
REQ-028 Sub-module epp_sync (parametrised-depth flop synchroniser, reset value 1) SHALL be instantiated for Astb, Dstb and Wr.

Verification
REQ-029 Address write 0x03, then data write 0xA5: regs_out[31:24]=0xA5; wr_stb pulses once with wr_addr=0x03, wr_data=0xA5; addr_out=0x04.
REQ-030 Address 0x0E, then three data writes 0x11,0x22,0x33 with NUM_REGS=16: reg14=0x11, reg15=0x22, 0x33 is discarded (addr 0x10), and addr_out=0x11.
REQ-031 Address 0xFF, status_in=0x5A, data read: Db=0x5A while Wait=1; addr_out=0x00 afterwards (wrap); Db is Z after Wait falls.
REQ-032 Astb and Dstb fall in the same cycle with Wr=0 and Db=0x07: only an address cycle occurs, addr_out=0x07, and no wr_stb.
REQ-033 rst asserted two cycles into a data write of 0x99: no register changes, Wait=0, Db=Z; the strobe held low after rst causes exactly one write.
REQ-034 Strobe held low for 50 cycles: Wait stays 1 and exactly one wr_stb pulse occurs; Wait falls within SYNC_STAGES+1 cycles of the strobe rising.

Source files
------------

// File: rtl/epp_pkg.sv
// Shared constants, state encoding and write-event payload for the EPP register file.
package epp_pkg;

    localparam int unsigned EPP_W = 8;
    localparam logic [EPP_W-1:0] STATUS_ADDR = 8'hFF;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_ADDR_WR = 3'd1;
    localparam logic [ST_W-1:0] ST_ADDR_RD = 3'd2;
    localparam logic [ST_W-1:0] ST_DATA_WR = 3'd3;
    localparam logic [ST_W-1:0] ST_DATA_RD = 3'd4;
    localparam logic [ST_W-1:0] ST_RELEASE = 3'd5;

    typedef struct packed {
        logic [EPP_W-1:0] addr;
        logic [EPP_W-1:0] data;
    } epp_wr_t;

endpackage

// File: rtl/epp_sync.sv
// Multi-flop synchroniser for one asynchronous EPP control line; resets to the idle-high level.
module epp_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/epp_regfile.sv
// EPP host port into a bank of 8-bit registers, with a read-only status byte at 0xFF.
module epp_regfile
    import epp_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned AUTO_INC    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    inout  wire  [EPP_W-1:0]          Db,
    input  logic                      Astb,
    input  logic                      Dstb,
    input  logic                      Wr,
    output logic                      Wait,
    output logic [EPP_W*NUM_REGS-1:0] regs_out,
    input  logic [EPP_W-1:0]          status_in,
    output logic                      wr_stb,
    output logic [EPP_W-1:0]          wr_addr,
    output logic [EPP_W-1:0]          wr_data,
    output logic [EPP_W-1:0]          addr_out
);

    logic astb_s, dstb_s, wr_s;

    epp_sync #(.STAGES(SYNC_STAGES)) u_sync_astb (.clk(clk), .rst(rst), .d(Astb), .q(astb_s));
    epp_sync #(.STAGES(SYNC_STAGES)) u_sync_dstb (.clk(clk), .rst(rst), .d(Dstb), .q(dstb_s));
    epp_sync #(.STAGES(SYNC_STAGES)) u_sync_wr   (.clk(clk), .rst(rst), .d(Wr),   .q(wr_s));

    logic [ST_W-1:0]  state_q, state_d;
    logic             wait_q, wait_d;
    logic             drv_q, drv_d;
    logic [EPP_W-1:0] latch_q, latch_d;
    logic [EPP_W-1:0] addr_q, addr_d;
    logic             wr_stb_q, wr_stb_d;
    epp_wr_t          wr_q, wr_d;
    logic             act_astb_q, act_astb_d;
    logic             data_cyc_q, data_cyc_d;
    logic             reg_we_c;
    logic [EPP_W-1:0] rd_data_c;
    logic [EPP_W-1:0] regs_q [NUM_REGS];

    // Data-read source: register bank, status byte, or zero for unmapped addresses.
    always_comb begin
        rd_data_c = '0;
        if (addr_q == STATUS_ADDR) begin
            rd_data_c = status_in;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == EPP_W'(i)) begin
                rd_data_c = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= 1'b0;
            drv_q      <= 1'b0;
            latch_q    <= '0;
            addr_q     <= '0;
            wr_stb_q   <= 1'b0;
            wr_q       <= '0;
            act_astb_q <= 1'b0;
            data_cyc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            drv_q      <= drv_d;
            latch_q    <= latch_d;
            addr_q     <= addr_d;
            wr_stb_q   <= wr_stb_d;
            wr_q       <= wr_d;
            act_astb_q <= act_astb_d;
            data_cyc_q <= data_cyc_d;
        end
    end

    // Read cycles load the latch on entry so Wait can follow one cycle later.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        drv_d      = drv_q;
        latch_d    = latch_q;
        addr_d     = addr_q;
        wr_stb_d   = 1'b0;
        wr_d       = wr_q;
        act_astb_d = act_astb_q;
        data_cyc_d = data_cyc_q;
        reg_we_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!astb_s) begin
                    act_astb_d = 1'b1;
                    data_cyc_d = 1'b0;
                    if (wr_s) begin
                        latch_d = addr_q;
                        drv_d   = 1'b1;
                        state_d = ST_ADDR_RD;
                    end else begin
                        state_d = ST_ADDR_WR;
                    end
                end else if (!dstb_s) begin
                    act_astb_d = 1'b0;
                    data_cyc_d = 1'b1;
                    if (wr_s) begin
                        latch_d = rd_data_c;
                        drv_d   = 1'b1;
                        state_d = ST_DATA_RD;
                    end else begin
                        state_d = ST_DATA_WR;
                    end
                end
            end
            ST_ADDR_WR: begin
                addr_d  = Db;
                wait_d  = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_DATA_WR: begin
                reg_we_c   = 1'b1;
                wr_stb_d   = 1'b1;
                wr_d.addr  = addr_q;
                wr_d.data  = Db;
                wait_d     = 1'b1;
                state_d    = ST_RELEASE;
            end
            ST_ADDR_RD, ST_DATA_RD: begin
                wait_d  = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (act_astb_q ? astb_s : dstb_s) begin
                    wait_d  = 1'b0;
                    drv_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (data_cyc_q && (AUTO_INC != 0)) begin
                        addr_d = addr_q + EPP_W'(1);
                    end
                end
            end
            default: begin
                wait_d  = 1'b0;
                drv_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes to unmapped addresses match no register and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == EPP_W'(i)) begin
                    regs_q[i] <= Db;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[EPP_W*g +: EPP_W] = regs_q[g];
    end

    assign Db       = drv_q ? latch_q : {EPP_W{1'bz}};
    assign Wait     = wait_q;
    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_q.addr;
    assign wr_data  = wr_q.data;
    assign addr_out = addr_q;

endmodule

// File: tb/tb_epp_regfile.sv
// Randomized EPP host against a behavioural register-file model; Db is pulled up so a released bus reads 0xFF.
module tb_epp_regfile;

    localparam int unsigned NUM_REGS    = 16;
    localparam int unsigned AUTO_INC    = 1;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          RISE_LIM    = SYNC_STAGES + 2;
    localparam int          FALL_LIM    = SYNC_STAGES + 1;

    logic clk = 1'b0;
    logic rst;
    logic Astb, Dstb, Wr;
    logic [7:0] status_in;
    logic [7:0] host_db;
    logic host_drv;
    wire  [7:0] Db;
    wire  Wait;
    wire  [8*NUM_REGS-1:0] regs_out;
    wire  wr_stb;
    wire  [7:0] wr_addr, wr_data, addr_out;

    epp_regfile #(
        .NUM_REGS(NUM_REGS), .AUTO_INC(AUTO_INC), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .Db(Db), .Astb(Astb), .Dstb(Dstb), .Wr(Wr),
        .Wait(Wait), .regs_out(regs_out), .status_in(status_in),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .addr_out(addr_out)
    );

    always #5 clk = ~clk;

    assign Db = host_drv ? host_db : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (Db[g]);
    end

    logic [7:0]  m_regs [NUM_REGS];
    logic [7:0]  m_addr;
    logic [15:0] wr_q [$];
    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) wr_q.push_back({wr_addr, wr_data});
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_addr = 8'h00;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            check_eq($sformatf("%s_reg%0d", tag, i), regs_out[8*i +: 8], m_regs[i]);
    endtask

    // One host handshake; pre=1 means the strobe is already low and only the completion is run.
    task automatic host_cycle(input bit is_addr, input bit both, input bit is_read,
                              input logic [7:0] wdata, input int hold, input bit pre,
                              output logic [7:0] rdata);
        int n;
        rdata = 8'h00;
        if (!pre) begin
            @(negedge clk);
            Wr       = is_read;
            host_db  = wdata;
            host_drv = !is_read;
            if (is_addr || both) Astb = 1'b0;
            if (!is_addr || both) Dstb = 1'b0;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (Wait !== 1'b1 && n < 40);
        check_eq("wait_rise_in_time", 8'(n <= RISE_LIM), 8'd1);
        if (is_read) rdata = Db;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq("wait_held_high", {7'd0, Wait}, 8'd1);
        end
        Astb = 1'b1;
        Dstb = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (Wait !== 1'b0 && n < 40);
        check_eq("wait_fall_in_time", 8'(n <= FALL_LIM), 8'd1);
        host_drv = 1'b0;
    endtask

    task automatic do_addr_wr(input logic [7:0] a, input bit both);
        logic [7:0] rd;
        host_cycle(1'b1, both, 1'b0, a, $urandom_range(0, 3), 1'b0, rd);
        m_addr = a;
        check_eq("addr_wr_no_stb", 8'(wr_q.size()), 8'd0);
        wr_q.delete();
        check_eq("addr_wr_addr_out", addr_out, m_addr);
    endtask

    task automatic do_data_wr(input logic [7:0] d, input int hold, input bit pre);
        logic [7:0] rd;
        logic [15:0] ev;
        host_cycle(1'b0, 1'b0, 1'b0, d, hold, pre, rd);
        check_eq("data_wr_stb_count", 8'(wr_q.size()), 8'd1);
        if (wr_q.size() != 0) begin
            ev = wr_q.pop_front();
            check_eq("data_wr_wr_addr", ev[15:8], m_addr);
            check_eq("data_wr_wr_data", ev[7:0], d);
        end
        wr_q.delete();
        if (m_addr < NUM_REGS) m_regs[m_addr] = d;
        if (AUTO_INC != 0) m_addr = m_addr + 8'd1;
        check_eq("data_wr_addr_out", addr_out, m_addr);
    endtask

    task automatic do_addr_rd();
        logic [7:0] rd;
        host_cycle(1'b1, 1'b0, 1'b1, 8'h00, $urandom_range(0, 3), 1'b0, rd);
        check_eq("addr_rd_value", rd, m_addr);
        check_eq("addr_rd_bus_released", Db, 8'hFF);
        check_eq("addr_rd_addr_out", addr_out, m_addr);
    endtask

    task automatic do_data_rd();
        logic [7:0] rd;
        logic [7:0] exp;
        exp = (m_addr < NUM_REGS) ? m_regs[m_addr] : ((m_addr == 8'hFF) ? status_in : 8'h00);
        host_cycle(1'b0, 1'b0, 1'b1, 8'h00, $urandom_range(0, 3), 1'b0, rd);
        check_eq("data_rd_value", rd, exp);
        check_eq("data_rd_bus_released", Db, 8'hFF);
        check_eq("data_rd_no_stb", 8'(wr_q.size()), 8'd0);
        wr_q.delete();
        if (AUTO_INC != 0) m_addr = m_addr + 8'd1;
        check_eq("data_rd_addr_out", addr_out, m_addr);
    endtask

    initial begin
        logic [7:0] a;
        rst = 1'b1; Astb = 1'b1; Dstb = 1'b1; Wr = 1'b1;
        host_db = 8'h00; host_drv = 1'b0; status_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_wait", {7'd0, Wait}, 8'd0);
        check_eq("rst_addr_out", addr_out, 8'h00);
        check_eq("rst_wr_stb", {7'd0, wr_stb}, 8'd0);
        check_eq("rst_wr_addr", wr_addr, 8'h00);
        check_eq("rst_wr_data", wr_data, 8'h00);
        check_eq("rst_bus_released", Db, 8'hFF);
        check_regs("rst");

        // Wr high with no strobe must not drive the bus.
        repeat (3) begin
            @(negedge clk);
            check_eq("wr_alone_no_drive", Db, 8'hFF);
        end

        do_addr_wr(8'h03, 1'b0);
        do_data_wr(8'hA5, 0, 1'b0);
        check_regs("single_wr");

        do_addr_wr(8'h0E, 1'b0);
        do_data_wr(8'h11, 0, 1'b0);
        do_data_wr(8'h22, 1, 1'b0);
        do_data_wr(8'h33, 2, 1'b0);
        check_eq("burst_addr_out", addr_out, 8'h11);
        check_regs("burst");

        do_addr_wr(8'hFF, 1'b0);
        status_in = 8'h5A;
        do_data_rd();
        check_eq("status_wrap_addr", addr_out, 8'h00);

        do_addr_wr(8'h07, 1'b1);
        check_eq("both_strobes_addr", addr_out, 8'h07);
        do_addr_rd();

        // Reset lands while the data write is in flight.
        do_addr_wr(8'h05, 1'b0);
        @(negedge clk);
        Wr = 1'b0; host_db = 8'h99; host_drv = 1'b1; Dstb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("rst_mid_wait", {7'd0, Wait}, 8'd0);
        check_eq("rst_mid_no_stb", 8'(wr_q.size()), 8'd0);
        check_eq("rst_mid_addr_out", addr_out, 8'h00);
        check_regs("rst_mid");
        do_data_wr(8'h99, 0, 1'b1);
        check_regs("after_rst");

        do_data_wr(8'hC3, 50, 1'b0);

        for (int op = 0; op < 80; op++) begin
            status_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    a = ($urandom_range(0, 3) == 0) ? 8'(240 + $urandom_range(0, 15))
                                                    : 8'($urandom_range(0, NUM_REGS - 1));
                    do_addr_wr(a, 1'b0);
                end
                1: do_data_wr(8'($urandom), $urandom_range(0, 4), 1'b0);
                2: do_addr_rd();
                default: do_data_rd();
            endcase
            if (op % 20 == 19) check_regs("rand");
        end
        check_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
